// File: rtl/apple_placer.sv
// apple_placer
//   Places the apple on a free cell. After reset and after every eaten apple
//   it samples a candidate from the free-running random generator. It rejects
//   the candidate if it lands on the snake head, or if the body occupancy
//   lookup reports a hit. It retries until a free cell is found.
//
// Ports
//   clk_25        system clock, rising edge
//   reset_game_n  synchronous active-low reset
//   random_x/y    candidate position from the random generator
//   head_x/y      current snake head
//   apple_eaten   single-cycle pulse from collision logic
//   query_valid   occupancy lookup request (held until query_done)
//   query_x/y     lookup position, equal to the registered candidate
//   query_done    lookup complete, qualified by query_valid
//   query_hit     candidate occupied, valid with query_done
//   apple_x/y     placed apple position
//   apple_valid   apple present and position stable
//   apple_count   apples eaten since reset, saturating
//   place_fail    one-cycle pulse after MAX_RETRY+1 consecutive rejections
module apple_placer #(
  parameter int POS_W     = 10,
  parameter int MAX_RETRY = 15,
  parameter int CNT_W     = 8
) (
  input  logic             clk_25,
  input  logic             reset_game_n,
  input  logic [POS_W-1:0] random_x,
  input  logic [POS_W-1:0] random_y,
  input  logic [POS_W-1:0] head_x,
  input  logic [POS_W-1:0] head_y,
  input  logic             apple_eaten,
  output logic             query_valid,
  output logic [POS_W-1:0] query_x,
  output logic [POS_W-1:0] query_y,
  input  logic             query_done,
  input  logic             query_hit,
  output logic [POS_W-1:0] apple_x,
  output logic [POS_W-1:0] apple_y,
  output logic             apple_valid,
  output logic [CNT_W-1:0] apple_count,
  output logic             place_fail
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0]    RMAX = RW'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {SAMPLE, CHECK, QUERY, HOLD} state_t;

  state_t           state, state_nx;
  logic [POS_W-1:0] cand_x, cand_y, cand_x_nx, cand_y_nx;
  logic [POS_W-1:0] apple_x_nx, apple_y_nx;
  logic [RW-1:0]    retry_cnt, retry_cnt_nx;
  logic [CNT_W-1:0] apple_count_nx;
  logic             apple_valid_nx, query_valid_nx, place_fail_nx;
  logic             reject;

  // The lookup address is the candidate register itself. The candidate is
  // only rewritten in SAMPLE, so it stays stable while the query is pending.
  assign query_x = cand_x;
  assign query_y = cand_y;

  always_ff @(posedge clk_25) begin
    if (!reset_game_n) begin
      state       <= SAMPLE;
      cand_x      <= '0;
      cand_y      <= '0;
      apple_x     <= '0;
      apple_y     <= '0;
      apple_valid <= 1'b0;
      query_valid <= 1'b0;
      retry_cnt   <= '0;
      apple_count <= '0;
      place_fail  <= 1'b0;
    end else begin
      state       <= state_nx;
      cand_x      <= cand_x_nx;
      cand_y      <= cand_y_nx;
      apple_x     <= apple_x_nx;
      apple_y     <= apple_y_nx;
      apple_valid <= apple_valid_nx;
      query_valid <= query_valid_nx;
      retry_cnt   <= retry_cnt_nx;
      apple_count <= apple_count_nx;
      place_fail  <= place_fail_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    cand_x_nx      = cand_x;
    cand_y_nx      = cand_y;
    apple_x_nx     = apple_x;
    apple_y_nx     = apple_y;
    apple_valid_nx = apple_valid;
    query_valid_nx = query_valid;
    retry_cnt_nx   = retry_cnt;
    apple_count_nx = apple_count;
    place_fail_nx  = 1'b0;
    reject         = 1'b0;

    case (state)
      SAMPLE: begin
        cand_x_nx = random_x;
        cand_y_nx = random_y;
        state_nx  = CHECK;
      end
      CHECK: begin
        // A head collision never reaches the occupancy memory.
        if (cand_x == head_x && cand_y == head_y) begin
          reject = 1'b1;
        end else begin
          query_valid_nx = 1'b1;
          state_nx       = QUERY;
        end
      end
      QUERY: begin
        if (query_valid && query_done) begin
          query_valid_nx = 1'b0;
          if (query_hit) begin
            reject = 1'b1;
          end else begin
            apple_x_nx     = cand_x;
            apple_y_nx     = cand_y;
            apple_valid_nx = 1'b1;
            retry_cnt_nx   = '0;
            state_nx       = HOLD;
          end
        end
      end
      HOLD: begin
        if (apple_eaten) begin
          apple_valid_nx = 1'b0;
          if (apple_count != CMAX) apple_count_nx = apple_count + CNT_W'(1);
          state_nx = SAMPLE;
        end
      end
      default: state_nx = SAMPLE;
    endcase

    // Retrying never stops. place_fail only reports a long run of rejections,
    // and the retry window then starts over.
    if (reject) begin
      state_nx = SAMPLE;
      if (retry_cnt == RMAX) begin
        place_fail_nx = 1'b1;
        retry_cnt_nx  = '0;
      end else begin
        retry_cnt_nx = retry_cnt + RW'(1);
      end
    end
  end

endmodule
